// File: rtl/pipe_stage_skid_if.sv
// Stream handshake bundle between an upstream producer, the skid stage and a downstream consumer.
// Latency: none, wires only.
// Backpressure: carries in_ready (stage to producer) and out_ready (consumer to stage).
// Signals:
//   in_valid/in_data/in_ready    - upstream payload handshake
//   out_valid/out_data/out_ready - downstream payload handshake
// Modports:
//   slave  - the pipeline stage (takes in_*, drives out_*)
//   master - the surrounding environment (drives in_*, takes out_*)
interface pipe_stage_skid_if #(
  parameter int DATA_W = 96
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage (main + skid registers) with flush and a saturating stall counter.
// Latency: 1 cycle from input transfer to out_valid; sustains 1 payload/cycle with out_ready high.
// Backpressure: in_ready is registered (no path from out_ready); the skid entry absorbs the in-flight payload.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (overrides everything)
//   bus         - slave side of the stream bundle (in_valid/in_data/in_ready, out_valid/out_data/out_ready)
//   flush       - discard both held payloads, clear main/skid to 0
//   occupancy   - number of held entries, 0..2
//   stall_cnt   - saturating count of cycles with out_valid && !out_ready
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  pipe_stage_skid_if.slave    bus,
  input  logic                flush,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt
);

  // State bits double as the entry valid bits: bit0 = main valid, bit1 = skid valid.
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b11;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_rdy;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_out_vld;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_stall;

  assign w_out_vld  = (r_state != S_EMPTY);
  assign w_in_xfer  = bus.in_valid && r_in_rdy;
  assign w_out_xfer = w_out_vld && bus.out_ready;
  assign w_stall    = w_out_vld && !bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = bus.in_data;
        end
      end
      S_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_nxt = bus.in_data;
        end else if (w_in_xfer) begin
          w_state_nxt = S_FULL;
          w_skid_nxt  = bus.in_data;
        end else if (w_out_xfer) begin
          // main keeps the consumed value so out_data holds it while empty
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only the drain move is possible
        if (w_out_xfer) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = r_skid;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_rdy    <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_main   <= w_main_nxt;
      r_skid   <= w_skid_nxt;
      // registered ready: look ahead at the next state instead of out_ready
      r_in_rdy <= (w_state_nxt != S_FULL);
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = r_in_rdy;
  assign bus.out_valid = w_out_vld;
  assign bus.out_data  = r_main;
  assign occupancy     = {r_state[1], r_state[0] & ~r_state[1]};
  assign stall_cnt     = r_stall_cnt;

endmodule
